// File: rtl/alu_exec_seq.sv
// Execute stage: ALUOp/funct decode, single-cycle ADD/SUB/SLT and an iterative shift-add MUL,
// with valid/ready handshakes toward ID/EX and EX/MEM.
module alu_exec_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [2:0]       alu_ctrl,
    output logic             busy
);

    localparam int unsigned StepDiv = (MUL_STEP == 0) ? 1 : MUL_STEP;
    localparam int unsigned Steps   = WIDTH / StepDiv;
    localparam int unsigned CntW    = $clog2(Steps + 1);

    localparam logic [2:0] CtrlAdd = 3'b010;
    localparam logic [2:0] CtrlSub = 3'b100;
    localparam logic [2:0] CtrlSlt = 3'b110;
    localparam logic [2:0] CtrlMul = 3'b101;

    if ((MUL_STEP == 0) || (WIDTH % StepDiv != 0) || (WIDTH < 4)) begin : g_bad_param
        $error("alu_exec_seq: MUL_STEP must divide WIDTH and WIDTH must be >= 4");
    end

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;

    logic [2:0]        ctrl_dec;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  step_acc;
    logic              accept;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign alu_ctrl  = ctrl_q;
    assign busy      = (state_q == StMul);

    always_comb begin
        ctrl_dec = CtrlAdd;
        case (alu_op)
            2'b00: ctrl_dec = CtrlAdd;
            2'b01: ctrl_dec = CtrlSub;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl_dec = CtrlAdd;
                    6'b100010: ctrl_dec = CtrlSub;
                    6'b101010: ctrl_dec = CtrlSlt;
                    6'b011100: ctrl_dec = CtrlMul;
                    default:   ctrl_dec = CtrlAdd;
                endcase
            end
            default: ctrl_dec = CtrlAdd;
        endcase
    end

    always_comb begin
        alu_res = src_a + src_b;
        case (ctrl_dec)
            CtrlSub: alu_res = src_a - src_b;
            CtrlSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = src_a + src_b;
        endcase
    end

    // One shift-add step: fold the low MUL_STEP multiplier bits into the accumulator.
    always_comb begin
        step_acc = acc_q;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                step_acc = step_acc + (mcand_q << i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        case (state_q)
            StIdle: begin
                out_valid_d = out_valid_q && !out_ready;
                if (accept) begin
                    if (ctrl_dec == CtrlMul) begin
                        mcand_d     = src_a;
                        mplier_d    = src_b;
                        acc_d       = '0;
                        cnt_d       = CntW'(Steps);
                        out_valid_d = 1'b0;
                        state_d     = StMul;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        ctrl_d      = ctrl_dec;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    result_d    = step_acc;
                    zero_d      = (step_acc == '0);
                    ctrl_d      = CtrlMul;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ctrl_q      <= CtrlAdd;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: decode, single-cycle ops, iterative MUL, handshake and reset.
module tb_alu_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b, result;
    logic [2:0]  alu_ctrl;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, busy2;
    logic [1:0]  alu_op2;
    logic [5:0]  funct2;
    logic [15:0] src_a2, src_b2, result2;
    logic [2:0]  alu_ctrl2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_seq #(.WIDTH(32), .MUL_STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .alu_ctrl(alu_ctrl), .busy(busy)
    );

    alu_exec_seq #(.WIDTH(16), .MUL_STEP(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_op(alu_op2), .funct(funct2), .src_a(src_a2), .src_b(src_b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .zero(zero2),
        .alu_ctrl(alu_ctrl2), .busy(busy2)
    );

    // Present one op for one clock edge, then deassert.
    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct = 6'd0; src_a = '0; src_b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; alu_op2 = 2'b00; funct2 = 6'd0;
        src_a2 = '0; src_b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL rst_result got %h exp 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rst_zero got %b exp 1", zero); end
        n_cmp++; if (alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL rst_ctrl got %b exp 010", alu_ctrl); end
        #2 rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
        issue(2'b10, 6'b100000, 32'd5, 32'd7);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b exp 1", out_valid); end
        n_cmp++; if (result !== 32'd12) begin n_bad++; $display("FAIL add_result got %h exp c", result); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b exp 0", zero); end
        n_cmp++; if (alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL add_ctrl got %b exp 010", alu_ctrl); end
    endtask

    task automatic test_sub;
        issue(2'b01, 6'b000000, 32'd9, 32'd9);
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL sub_eq_result got %h exp 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL sub_eq_zero got %b exp 1", zero); end
        n_cmp++; if (alu_ctrl !== 3'b100) begin n_bad++; $display("FAIL sub_ctrl got %b exp 100", alu_ctrl); end
        issue(2'b01, 6'b000000, 32'd3, 32'd5);
        n_cmp++; if (result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_neg_result got %h exp fffffffe", result); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL sub_neg_zero got %b exp 0", zero); end
        issue(2'b10, 6'b100010, 32'd20, 32'd6);
        n_cmp++; if (result !== 32'd14) begin n_bad++; $display("FAIL sub_funct_result got %h exp e", result); end
    endtask

    task automatic test_slt;
        issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        n_cmp++; if (result !== 32'd1) begin n_bad++; $display("FAIL slt_lt_result got %h exp 1", result); end
        n_cmp++; if (alu_ctrl !== 3'b110) begin n_bad++; $display("FAIL slt_ctrl got %b exp 110", alu_ctrl); end
        issue(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF);
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL slt_ge_result got %h exp 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL slt_ge_zero got %b exp 1", zero); end
        issue(2'b10, 6'b111111, 32'd2, 32'd3);
        n_cmp++; if (result !== 32'd5) begin n_bad++; $display("FAIL dflt_funct_result got %h exp 5", result); end
        n_cmp++; if (alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL dflt_funct_ctrl got %b exp 010", alu_ctrl); end
        issue(2'b11, 6'b101010, 32'd40, 32'd2);
        n_cmp++; if (result !== 32'd42) begin n_bad++; $display("FAIL aluop11_result got %h exp 2a", result); end
        issue(2'b00, 6'b011100, 32'd8, 32'd9);
        n_cmp++; if (result !== 32'd17) begin n_bad++; $display("FAIL aluop00_result got %h exp 11", result); end
    endtask

    task automatic test_mul;
        int bad_hold;
        int cyc;
        bad_hold = 0;
        issue(2'b10, 6'b011100, 32'h0001_2345, 32'h0000_0100);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_start_valid got %b exp 0", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul_start_busy got %b exp 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_start_in_ready got %b exp 0", in_ready); end
        // Competing op must be ignored while the multiply runs.
        alu_op = 2'b10; funct = 6'b100000; src_a = 32'hDEAD; src_b = 32'd1; in_valid = 1'b1;
        for (int k = 1; k < 32; k++) begin
            @(posedge clk); #1;
            if (out_valid || !busy || in_ready) bad_hold++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL mul_hold_cycles got %0d bad exp 0", bad_hold); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mul_done_valid got %b exp 1", out_valid); end
        n_cmp++; if (result !== 32'h0123_4500) begin n_bad++; $display("FAIL mul_result got %h exp 01234500", result); end
        n_cmp++; if (alu_ctrl !== 3'b101) begin n_bad++; $display("FAIL mul_ctrl got %b exp 101", alu_ctrl); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_done_busy got %b exp 0", busy); end

        issue(2'b10, 6'b011100, 32'h0001_0000, 32'h0001_0000);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (cyc !== 32) begin n_bad++; $display("FAIL mul_ovf_latency got %0d exp 32", cyc); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL mul_ovf_result got %h exp 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL mul_ovf_zero got %b exp 1", zero); end
    endtask

    task automatic test_mul_w16;
        int cyc;
        logic [15:0] exp_a [2];
        logic [15:0] exp_b [2];
        logic [15:0] exp_r [2];
        exp_a = '{16'h1234, 16'hFFFF};
        exp_b = '{16'h0010, 16'hFFFF};
        exp_r = '{16'h2340, 16'h0001};
        for (int t = 0; t < 2; t++) begin
            alu_op2 = 2'b10; funct2 = 6'b011100; src_a2 = exp_a[t]; src_b2 = exp_b[t];
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            cyc = 0;
            while (!out_valid2 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL mul16_latency[%0d] got %0d exp 4", t, cyc); end
            n_cmp++; if (result2 !== exp_r[t]) begin n_bad++; $display("FAIL mul16_result[%0d] got %h exp %h", t, result2, exp_r[t]); end
            n_cmp++; if (alu_ctrl2 !== 3'b101) begin n_bad++; $display("FAIL mul16_ctrl[%0d] got %b exp 101", t, alu_ctrl2); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] op_a [4];
        logic [31:0] op_b [4];
        logic [31:0] exp_s [4];
        logic [31:0] held;
        int idx, got, cyc;
        logic consume, take, hold;
        op_a  = '{32'd1, 32'd10, 32'd100, 32'd7};
        op_b  = '{32'd1, 32'd20, 32'd200, 32'd8};
        exp_s = '{32'd2, 32'd30, 32'd300, 32'd15};
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        idx = 0; got = 0; cyc = 0; held = '0;
        alu_op = 2'b10; funct = 6'b100000; src_a = op_a[0]; src_b = op_b[0]; in_valid = 1'b1;
        while (got < 4 && cyc < 20) begin
            out_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
            #1;
            consume = out_valid && out_ready;
            take    = in_valid && in_ready;
            hold    = out_valid && !out_ready;
            if (consume) begin
                n_cmp++; if (result !== exp_s[got]) begin n_bad++; $display("FAIL b2b_result[%0d] got %h exp %h", got, result, exp_s[got]); end
                got++;
            end
            if (hold) begin
                held = result;
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_in_ready got %b exp 0", in_ready); end
            end
            @(posedge clk); #1;
            if (take) begin
                idx++;
                if (idx < 4) begin
                    src_a = op_a[idx]; src_b = op_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (hold) begin
                n_cmp++; if (result !== held) begin n_bad++; $display("FAIL b2b_hold_result got %h exp %h", result, held); end
            end
            cyc++;
        end
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL b2b_count got %0d exp 4", got); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup got %b exp 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_mul;
        issue(2'b10, 6'b011100, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL mid_rst_result got %h exp 0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL mid_rst_zero got %b exp 1", zero); end
        n_cmp++; if (alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL mid_rst_ctrl got %b exp 010", alu_ctrl); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
        #2 rst_n = 1'b1;
        #1;
        issue(2'b10, 6'b100000, 32'd100, 32'd23);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL post_rst_valid got %b exp 1", out_valid); end
        n_cmp++; if (result !== 32'd123) begin n_bad++; $display("FAIL post_rst_result got %h exp 7b", result); end
        n_cmp++; if (alu_ctrl !== 3'b010) begin n_bad++; $display("FAIL post_rst_ctrl got %b exp 010", alu_ctrl); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy got %b exp 0", busy); end
        repeat (35) @(posedge clk);
        #1;
        n_cmp++; if (result !== 32'd123) begin n_bad++; $display("FAIL post_rst_discard got %h exp 7b", result); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle_valid got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_mul();
        test_mul_w16();
        test_back_to_back();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
